input_debouncer_8: RTL and testbench
====================================

Name: input_debouncer_8

Overview:
- 8-channel active-low push-button conditioner. It sits directly upstream of the 8-to-3 priority encoder and drives the encoder's active-low request lines x[7:0].
- Synchronises raw board inputs to clk and debounces each channel on a shared sample tick.
- Optionally holds each press (sticky) until the consumer clears it, so short presses are not lost before the encoded value is read.

Parameters:
- TICK_DIV, 100000: clk cycles per debounce sample tick (1 ms at 100 MHz); legal range ≥2.
- STABLE_COUNT, 10: consecutive mismatching samples required before a channel's stable level flips; legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_n  input  8  raw asynchronous buttons; active-low (0 = pressed).
- sticky_en  input  1  1 = x_n shows latched presses; 0 = x_n shows live debounced level.
- clr  input  8  per-channel clear of the latched press; one-cycle pulses; active-high.
- x_n  output  8  request lines to the priority encoder; active-low.
- db_n  output  8  live debounced level per channel; active-low.
- press  output  8  one-cycle pulse per channel on a debounced press (db_n falling edge).
- any_n  output  1  AND-reduce of x_n; 0 when any request is asserted.

Behaviour:
- Reset, synchronous, active-high. On any clk edge with rst=1:
  - sync flops, db_n, sticky, x_n and any_n all go to 1 (released).
  - press goes to 0.
  - Prescaler and all channel counters go to 0.
  - rst overrides every other input, including during an in-progress debounce.
- Synchroniser: 2 flops per bit; sync_n = btn_n delayed 2 clk cycles.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the one cycle in which count==TICK_DIV-1.
- Per-channel debounce, evaluated only on cycles with tick=1:
  - If sync_n[i]==db_n[i]: cnt[i] <= 0.
  - Else if cnt[i]==STABLE_COUNT-1: db_n[i] <= sync_n[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - cnt width is clog2(STABLE_COUNT), minimum 1 bit.
  - A single matching sample resets the count, so glitches shorter than STABLE_COUNT ticks never propagate.
- press[i] = 1 for exactly the cycle after db_n[i] transitions 1→0 (registered edge detect). No pulse is generated on release.
- Sticky latch:
  - sticky[i] <= 0 when db_n[i] transitions 1→0.
  - sticky[i] <= 1 on clr[i]=1, but only while db_n[i]=1.
  - clr on a still-held button is ignored: the latch stays 0.
  - Simultaneous press edge and clr on the same cycle: the press wins.
- x_n = sticky_en ? sticky : db_n. This is a combinational mux of registered signals; any_n = &x_n.
- Toggling sticky_en does not alter sticky state. Latches keep updating whatever the value of sticky_en.
- Latency:
  - From a btn_n edge to db_n change: 2 cycles (sync) + STABLE_COUNT ticks, measured from the first tick after sync.
  - From the db_n change to press: +1 cycle.
- Channels are fully independent; all 8 may change on the same tick.
- Encoder contract: x_n is always a registered, glitch-free level. The encoder's enable input is not driven by this block.

Decomposition:
- Shared package: NUM_LINES=8, LINE_RELEASED=1'b1, and a function for the cnt width (clog2).
- Sub-module debounce_channel, instantiated 8× via generate. Its ports: clk, rst, tick, in_n, clr, db_n, press, sticky_n.
- The top level holds the synchroniser, the prescaler, the x_n mux and any_n.

Test Plan (TICK_DIV=4, STABLE_COUNT=3 unless noted):
1. Reset check → rst=1 for 2 cycles with btn_n=8'h00 → x_n=db_n=8'hFF, press=0, any_n=1 during and immediately after reset.
2. Clean press → btn_n[3] held 0 → db_n=8'hF7 after 2 sync cycles + 3 ticks (±1 tick of phase); press=8'h08 for exactly 1 cycle; any_n=0.
3. Glitch rejection → btn_n[5] low for 2 ticks, then high → db_n stays 8'hFF and press stays 0 throughout.
4. Sticky hold, sticky_en=1 → press btn 6, release it fully, wait → x_n stays 8'hBF until clr=8'h40, then x_n=8'hFF the next cycle. clr issued while the button is still held → x_n stays 8'hBF.
5. Simultaneous activity → press ch0 and ch7 on the same cycle → both db_n bits fall on the same tick; press=8'h81 for one cycle. Then clr=8'h01 with the ch0 press edge on the same cycle → sticky[0] stays 0.
6. Reset mid-debounce → btn_n[2]=0; rst pulsed after 2 ticks → cnt cleared; db_n[2] falls only after a full fresh 3 ticks post-reset. Separately, TICK_DIV=2 and STABLE_COUNT=1 → flip on the first mismatching tick.

Source files
------------

// File: rtl/input_debouncer_8_pkg.sv
// Shared definitions for the 8-line active-low button conditioner.
//   NUM_LINES     : number of request lines driven toward the priority encoder
//   LINE_RELEASED : idle (not pressed) level of an active-low line
//   cnt_width()   : bit width of a debounce counter that must reach STABLE_COUNT-1
package input_debouncer_8_pkg;

  localparam int   NUM_LINES     = 8;
  localparam logic LINE_RELEASED = 1'b1;

  // Counter must hold STABLE_COUNT-1; a single-sample debounce still needs one bit.
  function automatic int cnt_width(input int stable_count);
    int w;
    w = $clog2(stable_count);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/input_debouncer_8_channel.sv
// One debounce channel: stable-level filter, press-edge pulse and sticky latch.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   tick     in  shared sample strobe; the filter only advances when high
//   in_n     in  synchronised raw level (active-low)
//   clr      in  clears the sticky latch while the debounced level is released
//   db_n     out debounced level (active-low)
//   press    out one-cycle pulse the cycle after db_n falls
//   sticky_n out latched press, held low until cleared after release
module debounce_channel
  import input_debouncer_8_pkg::*;
#(
  parameter int STABLE_COUNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in_n,
  input  logic clr,
  output logic db_n,
  output logic press,
  output logic sticky_n
);

  localparam int               CNT_W    = cnt_width(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_db_n;
  logic             r_db_prev_n;
  logic             r_press;
  logic             r_sticky_n;

  logic             w_mismatch;
  logic             w_flip;
  logic             w_fall;

  always_comb begin
    w_mismatch = (in_n != r_db_n);
    w_flip     = tick && w_mismatch && (r_cnt == CNT_LAST);
    // A flip while the stable level is released can only be a press.
    w_fall     = w_flip && r_db_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_db_n      <= LINE_RELEASED;
      r_db_prev_n <= LINE_RELEASED;
      r_press     <= 1'b0;
      r_sticky_n  <= LINE_RELEASED;
    end else begin
      if (tick) begin
        if (!w_mismatch) begin
          r_cnt <= '0;
        end else if (w_flip) begin
          r_db_n <= in_n;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      r_db_prev_n <= r_db_n;
      r_press     <= r_db_prev_n & ~r_db_n;
      // The press edge outranks a coincident clear; clearing a held button is ignored.
      if (w_fall) begin
        r_sticky_n <= 1'b0;
      end else if (clr && r_db_n) begin
        r_sticky_n <= LINE_RELEASED;
      end
    end
  end

  assign db_n     = r_db_n;
  assign press    = r_press;
  assign sticky_n = r_sticky_n;

endmodule

// File: rtl/input_debouncer_8.sv
// 8-channel active-low push-button conditioner feeding an 8-to-3 priority encoder.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   btn_n     in  [7:0] raw asynchronous buttons, 0 = pressed
//   sticky_en in  1 = x_n shows latched presses, 0 = live debounced level
//   clr       in  [7:0] per-channel clear of the latched press
//   x_n       out [7:0] request lines to the encoder (active-low)
//   db_n      out [7:0] live debounced level (active-low)
//   press     out [7:0] one-cycle pulse per debounced press
//   any_n     out 0 when any request line is asserted
module input_debouncer_8
  import input_debouncer_8_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_COUNT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] btn_n,
  input  logic                 sticky_en,
  input  logic [NUM_LINES-1:0] clr,
  output logic [NUM_LINES-1:0] x_n,
  output logic [NUM_LINES-1:0] db_n,
  output logic [NUM_LINES-1:0] press,
  output logic                 any_n
);

  localparam int               PRE_W    = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [NUM_LINES-1:0] r_sync1_n;
  logic [NUM_LINES-1:0] r_sync2_n;
  logic [PRE_W-1:0]     r_presc;

  logic                 w_tick;
  logic [NUM_LINES-1:0] w_db_n;
  logic [NUM_LINES-1:0] w_press;
  logic [NUM_LINES-1:0] w_sticky_n;

  // Stage: two-flop synchroniser; sync reset forces the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1_n <= {NUM_LINES{LINE_RELEASED}};
      r_sync2_n <= {NUM_LINES{LINE_RELEASED}};
    end else begin
      r_sync1_n <= btn_n;
      r_sync2_n <= r_sync1_n;
    end
  end

  // Stage: sample-tick prescaler, strobe on the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (r_presc == PRE_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PRE_LAST);

  // Stage: independent per-line debounce and latch.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_COUNT(STABLE_COUNT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (w_tick),
      .in_n    (r_sync2_n[gi]),
      .clr     (clr[gi]),
      .db_n    (w_db_n[gi]),
      .press   (w_press[gi]),
      .sticky_n(w_sticky_n[gi])
    );
  end

  // Both mux inputs are flop outputs, so x_n only glitches when sticky_en itself moves.
  assign x_n   = sticky_en ? w_sticky_n : w_db_n;
  assign any_n = &x_n;
  assign db_n  = w_db_n;
  assign press = w_press;

endmodule

// File: tb/tb_input_debouncer_8.sv
module tb_input_debouncer_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sticky_en;
  logic [7:0] btn_n;
  logic [7:0] clr;
  logic [7:0] x_n, db_n, press;
  logic       any_n;
  logic [7:0] f_x_n, f_db_n, f_press;
  logic       f_any_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_debouncer_8 #(.TICK_DIV(4), .STABLE_COUNT(3)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .sticky_en(sticky_en), .clr(clr),
    .x_n(x_n), .db_n(db_n), .press(press), .any_n(any_n)
  );

  input_debouncer_8 #(.TICK_DIV(2), .STABLE_COUNT(1)) dut_fast (
    .clk(clk), .rst(rst), .btn_n(btn_n), .sticky_en(sticky_en), .clr(clr),
    .x_n(f_x_n), .db_n(f_db_n), .press(f_press), .any_n(f_any_n)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: index 0 = (4,3), index 1 = (2,1)
  function automatic int td_of(input int k); return (k == 0) ? 4 : 2; endfunction
  function automatic int sc_of(input int k); return (k == 0) ? 3 : 1; endfunction

  logic [7:0] m_s1, m_s2;
  logic [7:0] m_db[2], m_sticky[2], m_press[2], m_fellp[2];
  int         m_run[2][8];
  int         m_n;
  bit         m_valid = 0;

  always @(posedge clk) begin : model
    logic [7:0] fall, ndb;
    bit         tk;
    if (rst) begin
      m_valid = 1;
      m_s1 = 8'hFF; m_s2 = 8'hFF; m_n = 0;
      for (int k = 0; k < 2; k++) begin
        m_db[k] = 8'hFF; m_sticky[k] = 8'hFF; m_press[k] = 8'h00; m_fellp[k] = 8'h00;
        for (int i = 0; i < 8; i++) m_run[k][i] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        tk   = (m_n % td_of(k)) == td_of(k) - 1;
        fall = 8'h00;
        ndb  = m_db[k];
        if (tk) begin
          for (int i = 0; i < 8; i++) begin
            if (m_s2[i] == m_db[k][i]) m_run[k][i] = 0;
            else if (m_run[k][i] + 1 >= sc_of(k)) begin
              ndb[i] = m_s2[i];
              m_run[k][i] = 0;
              if (!m_s2[i]) fall[i] = 1'b1;
            end else m_run[k][i] = m_run[k][i] + 1;
          end
        end
        m_press[k]  = m_fellp[k];
        m_fellp[k]  = fall;
        m_sticky[k] = (m_sticky[k] | (clr & m_db[k])) & ~fall;
        m_db[k]     = ndb;
      end
      m_n  = m_n + 1;
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin : cmp
    logic [7:0] ex0, ex1;
    if (m_valid) begin
      ex0 = sticky_en ? m_sticky[0] : m_db[0];
      ex1 = sticky_en ? m_sticky[1] : m_db[1];
      chk("m_db_n",   db_n,  m_db[0]);
      chk("m_press",  press, m_press[0]);
      chk("m_x_n",    x_n,   ex0);
      chk("m_any_n",  {7'd0, any_n}, {7'd0, &ex0});
      chk("mf_db_n",  f_db_n,  m_db[1]);
      chk("mf_press", f_press, m_press[1]);
      chk("mf_x_n",   f_x_n,   ex1);
      chk("mf_any_n", {7'd0, f_any_n}, {7'd0, &ex1});
    end
  end

  // ---------------- stimulus with hand-computed expectations
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_release(input logic [7:0] b);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    btn_n = b;
  endtask

  task automatic wait_db(input logic [7:0] exp, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (db_n == exp) break;
      step();
    end
    chk("wait_db", db_n, exp);
  endtask

  task automatic pulse_clr(input logic [7:0] c);
    clr = c;
    step();
    clr = 8'h00;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; btn_n = 8'h00; clr = 8'h00; sticky_en = 1'b0;

    // 1. reset
    step(); step();
    chk("rst_x_n", x_n, 8'hFF);
    chk("rst_db_n", db_n, 8'hFF);
    chk("rst_press", press, 8'h00);
    chk("rst_any_n", {7'd0, any_n}, 8'h01);
    rst = 1'b0; btn_n = 8'hFF;
    step();
    chk("post_rst_x_n", x_n, 8'hFF);
    chk("post_rst_any_n", {7'd0, any_n}, 8'h01);

    // 2. clean press of line 3, from a known prescaler phase
    reset_release(8'hF7);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("p2_db",     db_n,    (k >= 12) ? 8'hF7 : 8'hFF);
      chk("p2_press",  press,   (k == 13) ? 8'h08 : 8'h00);
      chk("p2_fdb",    f_db_n,  (k >= 4)  ? 8'hF7 : 8'hFF);
      chk("p2_fpress", f_press, (k == 5)  ? 8'h08 : 8'h00);
    end
    chk("p2_any_n", {7'd0, any_n}, 8'h00);
    btn_n = 8'hFF;
    wait_db(8'hFF, 40);

    // 3. glitch of 8 cycles on line 5 spans only two ticks
    btn_n = 8'hDF;
    for (int k = 0; k < 28; k++) begin
      if (k == 8) btn_n = 8'hFF;
      step();
      chk("p3_db", db_n, 8'hFF);
      chk("p3_press", press, 8'h00);
    end

    // 4. sticky hold on line 6
    pulse_clr(8'hFF);
    step();
    sticky_en = 1'b1;
    #1 chk("p4_idle", x_n, 8'hFF);
    btn_n = 8'hBF;
    wait_db(8'hBF, 40);
    btn_n = 8'hFF;
    wait_db(8'hFF, 40);
    repeat (5) step();
    chk("p4_held", x_n, 8'hBF);
    chk("p4_any_n", {7'd0, any_n}, 8'h00);
    sticky_en = 1'b0;
    #1 chk("p4_live", x_n, 8'hFF);
    sticky_en = 1'b1;
    #1 chk("p4_relatch", x_n, 8'hBF);
    pulse_clr(8'h40);
    chk("p4_cleared", x_n, 8'hFF);
    btn_n = 8'hBF;
    wait_db(8'hBF, 40);
    pulse_clr(8'h40);
    chk("p4_clr_held", x_n, 8'hBF);
    btn_n = 8'hFF;
    wait_db(8'hFF, 40);
    chk("p4_after_rel", x_n, 8'hBF);
    pulse_clr(8'h40);
    chk("p4_cleared2", x_n, 8'hFF);

    // 5. lines 0 and 7 together; clr held across the line-0 press edge
    clr   = 8'h01;
    btn_n = 8'h7E;
    for (int i = 0; i < 40; i++) begin
      if (db_n != 8'hFF) break;
      step();
    end
    chk("p5_same_tick", db_n, 8'h7E);
    clr = 8'h00;
    step();
    chk("p5_press", press, 8'h81);
    chk("p5_sticky", x_n, 8'h7E);
    step();
    chk("p5_press_end", press, 8'h00);
    btn_n = 8'hFF;
    wait_db(8'hFF, 40);
    pulse_clr(8'hFF);
    chk("p5_cleared", x_n, 8'hFF);

    // 6. reset in the middle of a debounce of line 2
    sticky_en = 1'b0;
    reset_release(8'hFB);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("p6_pre_db", db_n, 8'hFF);
    end
    rst = 1'b1;
    step();
    chk("p6_rst_x_n", x_n, 8'hFF);
    chk("p6_rst_fdb", f_db_n, 8'hFF);
    chk("p6_rst_any_n", {7'd0, any_n}, 8'h01);
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("p6_db",    db_n,   (k >= 12) ? 8'hFB : 8'hFF);
      chk("p6_press", press,  (k == 13) ? 8'h04 : 8'h00);
      chk("p6_fdb",   f_db_n, (k >= 4)  ? 8'hFB : 8'hFF);
    end
    btn_n = 8'hFF;
    wait_db(8'hFF, 40);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
